// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory subsystem.
//   ADDR_W / DATA_W : word address and word width of the 4K x 32b RAM.
//   ST_*            : ram_arbiter FSM state encoding (kept as plain
//                     localparams so older tools and waveforms match).
package cpu_mem_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection for ram_arbiter (purely combinational).
//   req_valid : pending requests, one bit per requester
//   rr_last   : index of the most recent winner
//   winner    : first requester with req_valid set, searching upward from
//               rr_last+1 and wrapping modulo N_REQ
//   any_req   : at least one request is pending (winner is meaningful)
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_last,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a value before the loop so no path through the
    // block leaves one unassigned; otherwise synthesis would infer a latch.
    winner  = rr_last;
    any_req = |req_valid;
    found   = 1'b0;
    cand    = '0;
    // rr_last itself is visited last, so it only wins again when alone.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_last) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port word RAM between N_REQ requesters
// (0 = load/store data port, 1 = instruction fetch, 2 = debug loader).
// Round-robin arbitration with one transaction in flight:
//   IDLE -> ACCESS -> WAIT x RAM_LAT (reads only) -> RESP -> IDLE
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/we          per-requester request and write flag
//   req_addr/wdata        flattened per-requester address and write data
//   req_gnt               one-cycle grant pulse (request consumed)
//   rsp_valid             one-cycle completion pulse to the granted requester
//   rsp_rdata             read data, held between reads
//   ram_en/we/addr/wdata  RAM macro strobe, write enable, address, data
//   ram_rdata             RAM read data, valid RAM_LAT cycles after ram_en
//   busy                  a transaction is in progress
module ram_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W  = cpu_mem_pkg::DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  import cpu_mem_pkg::STATE_W;
  import cpu_mem_pkg::ST_IDLE;
  import cpu_mem_pkg::ST_ACCESS;
  import cpu_mem_pkg::ST_WAIT;
  import cpu_mem_pkg::ST_RESP;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LAT_W = $clog2(RAM_LAT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [STATE_W-1:0] state;
  logic [IDX_W-1:0]   rr_last;
  logic [IDX_W-1:0]   cur_idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic [IDX_W-1:0]   winner;
  logic               any_req;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_last   (rr_last),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign busy = (state != ST_IDLE);

  // ram_we/addr/wdata double as the transaction latch: they are loaded when
  // the request is accepted, so the ACCESS cycle drives them straight out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_last   <= IDX_W'(N_REQ - 1);
      cur_idx   <= '0;
      lat_cnt   <= '0;
      req_gnt   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      req_gnt   <= '0;
      rsp_valid <= '0;
      ram_en    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cur_idx   <= winner;
            rr_last   <= winner;
            ram_en    <= 1'b1;
            ram_we    <= req_we[winner];
            ram_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            ram_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
            req_gnt   <= ONE << winner;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Writes complete on the strobe itself; reads wait for the macro.
          if (ram_we) begin
            rsp_valid <= ONE << cur_idx;
            state     <= ST_RESP;
          end else begin
            lat_cnt <= LAT_W'(RAM_LAT);
            state   <= ST_WAIT;
          end
          ram_we <= 1'b0;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            rsp_rdata <= ram_rdata;
            rsp_valid <= ONE << cur_idx;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. Two lanes share the same requester stimulus:
// lane 0 builds the arbiter with RAM_LAT=1, lane 1 with RAM_LAT=3. Each lane
// has its own RAM stub, a transaction-schedule model and a per-cycle compare.
module tb_ram_arbiter;

  localparam int N    = 3;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXC = 2048;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Initial RAM contents, known to both the stub and the model.
  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(a));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [N-1:0]  req_gnt, rsp_valid;
    logic [DW-1:0] rsp_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_en, ram_we, busy;

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM stub: writes land on the strobe edge, read data appears exactly LAT
    // cycles after the strobe cycle and is junk at all other times.
    logic [DW-1:0] smem [4096];
    bit            swr  [4096];
    bit   [LAT-1:0] pv;
    logic [DW-1:0] pd [LAT];

    always @(posedge clk) begin
      if (ram_en && ram_we) begin
        smem[ram_addr] <= ram_wdata;
        swr[ram_addr]  <= 1'b1;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= ram_en && !ram_we;
      pd[0] <= swr[ram_addr] ? smem[ram_addr] : init_word(int'(ram_addr));
    end

    assign ram_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBADC_0FFE;

    // Model: when the arbiter is free it picks a round-robin winner and
    // schedules what each output must show in each future cycle.
    int            t = 0;
    bit [N-1:0]    e_gnt [MAXC];
    bit [N-1:0]    e_rsp [MAXC];
    bit            e_en  [MAXC];
    bit            e_we  [MAXC];
    bit            e_busy[MAXC];
    bit            e_rd  [MAXC];
    bit [AW-1:0]   e_addr [MAXC];
    bit [DW-1:0]   e_wdata[MAXC];
    bit [DW-1:0]   e_rdata[MAXC];
    logic [DW-1:0] m_mem [4096];
    bit            m_wr  [4096];

    initial begin : model
      int w, done, m_rr, m_free;
      logic [AW-1:0] a;
      m_rr   = N - 1;
      m_free = 0;
      forever begin
        @(posedge clk);
        t = t + 1;
        if (!rst_n) begin
          for (int i = t; i < t + 16 && i < MAXC; i++) begin
            e_gnt[i] = '0; e_rsp[i] = '0; e_en[i] = 0; e_busy[i] = 0; e_rd[i] = 0;
          end
          m_rr   = N - 1;
          m_free = t + 1;
        end else if (t >= m_free && req_valid != '0 && t + LAT + 2 < MAXC) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
          m_rr = w;
          a = req_addr[w*AW +: AW];
          e_gnt[t]   = N'(1) << w;
          e_en[t]    = 1'b1;
          e_we[t]    = req_we[w];
          e_addr[t]  = a;
          e_wdata[t] = req_wdata[w*DW +: DW];
          if (req_we[w]) begin
            m_mem[a] = req_wdata[w*DW +: DW];
            m_wr[a]  = 1'b1;
            done = t + 1;
          end else begin
            done = t + 1 + LAT;
            e_rd[done]    = 1'b1;
            e_rdata[done] = m_wr[a] ? m_mem[a] : init_word(int'(a));
          end
          e_rsp[done] = N'(1) << w;
          for (int i = t; i <= done; i++) e_busy[i] = 1'b1;
          m_free = done + 2;
        end
      end
    end

    initial begin : compare
      logic [DW-1:0] m_rdata;
      m_rdata = '0;
      forever begin
        @(negedge clk);
        if (t > 0 && t < MAXC) begin
          if (!rst_n) begin
            m_rdata = '0;
            check($sformatf("L%0d reset gnt", g), 32'(req_gnt), 0);
            check($sformatf("L%0d reset rsp_valid", g), 32'(rsp_valid), 0);
            check($sformatf("L%0d reset rsp_rdata", g), rsp_rdata, 0);
            check($sformatf("L%0d reset ram_en", g), 32'(ram_en), 0);
            check($sformatf("L%0d reset busy", g), 32'(busy), 0);
          end else begin
            if (e_rd[t]) m_rdata = e_rdata[t];
            check($sformatf("L%0d gnt c%0d", g, t), 32'(req_gnt), 32'(e_gnt[t]));
            check($sformatf("L%0d rsp_valid c%0d", g, t), 32'(rsp_valid), 32'(e_rsp[t]));
            check($sformatf("L%0d rsp_rdata c%0d", g, t), rsp_rdata, m_rdata);
            check($sformatf("L%0d ram_en c%0d", g, t), 32'(ram_en), 32'(e_en[t]));
            check($sformatf("L%0d busy c%0d", g, t), 32'(busy), 32'(e_busy[t]));
            check($sformatf("L%0d onehot c%0d", g, t),
                  32'($onehot0(req_gnt) && $onehot0(rsp_valid)), 1);
            if (e_en[t]) begin
              check($sformatf("L%0d ram_we c%0d", g, t), 32'(ram_we), 32'(e_we[t]));
              check($sformatf("L%0d ram_addr c%0d", g, t), 32'(ram_addr), 32'(e_addr[t]));
              check($sformatf("L%0d ram_wdata c%0d", g, t), ram_wdata, e_wdata[t]);
            end
          end
        end
      end
    end
  end

  // One-cycle request from requester i; returns at posedge+2 of the cycle
  // right after the sampling edge (the ACCESS cycle of an idle arbiter).
  task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    @(posedge clk);
    #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((lane[0].busy || lane[1].busy) && n < 50);
    check("wait_idle in time", 32'(n < 50), 1);
  endtask

  task automatic wait_rsp0(input int i, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lane[0].rsp_valid[i] && n < 20);
    check(name, 32'(n < 20), 1);
  endtask

  initial begin
    int got[$];
    int n;

    // Reset held with all three requesters asking.
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {12'h300, 12'h200, 12'h100};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset gnt", 32'(lane[0].req_gnt), 0);
    check("reset rsp_rdata", lane[0].rsp_rdata, 0);
    check("reset busy", 32'(lane[0].busy), 0);
    check("reset ram_addr", 32'(lane[0].ram_addr), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Contention: requests held, expected order 0,1,2,0,1,2.
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) if (lane[0].req_gnt[j]) got.push_back(j);
    end
    check("contention grant count", 32'(got.size()), 6);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("grant order [%0d]", i), 32'(got[i]), 32'(i % 3));
    @(negedge clk);
    req_valid = '0;
    wait_idle();

    // Single read of 0x005 by requester 1.
    issue(1, 1'b0, 12'h005, '0);
    @(negedge clk);
    check("read t1 gnt", 32'(lane[0].req_gnt), 32'b010);
    check("read t1 ram_en", 32'(lane[0].ram_en), 1);
    check("read t1 ram_addr", 32'(lane[0].ram_addr), 32'h005);
    @(negedge clk);
    check("read t2 no rsp", 32'(lane[0].rsp_valid), 0);
    @(negedge clk);
    check("read t3 rsp_valid", 32'(lane[0].rsp_valid), 32'b010);
    check("read t3 rsp_rdata", lane[0].rsp_rdata, 32'hDEAD_BEEF);
    wait_idle();

    // Write the last word, then read it back.
    issue(0, 1'b1, 12'hFFF, 32'h1234_5678);
    @(negedge clk);
    check("write t1 gnt", 32'(lane[0].req_gnt), 32'b001);
    check("write t1 ram_we", 32'(lane[0].ram_we), 1);
    check("write t1 ram_addr", 32'(lane[0].ram_addr), 32'hFFF);
    @(negedge clk);
    check("write t2 ack", 32'(lane[0].rsp_valid), 32'b001);
    check("write keeps rsp_rdata", lane[0].rsp_rdata, 32'hDEAD_BEEF);
    wait_idle();
    issue(0, 1'b0, 12'hFFF, '0);
    wait_rsp0(0, "readback rsp in time");
    check("readback rsp_rdata", lane[0].rsp_rdata, 32'h1234_5678);
    wait_idle();

    // Withdrawal: requester 2 pulses once while requester 0 is served.
    issue(0, 1'b0, 12'h010, '0);
    req_valid[2] = 1'b1;
    req_addr[2*AW +: AW] = 12'h020;
    @(posedge clk);
    #2;
    req_valid[2] = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (lane[0].req_gnt[2] || lane[0].rsp_valid[2] ||
          lane[1].req_gnt[2] || lane[1].rsp_valid[2]) n++;
    end
    check("withdrawn req 2 activity", 32'(n), 0);
    wait_idle();

    // Reset during WAIT of the RAM_LAT=3 lane.
    issue(1, 1'b0, 12'h005, '0);
    @(negedge clk);
    check("L1 read strobe", 32'(lane[1].ram_en), 1);
    @(posedge clk);
    #2;
    check("L1 busy before reset", 32'(lane[1].busy), 1);
    rst_n = 1'b0;
    #1;
    check("L1 mid reset busy", 32'(lane[1].busy), 0);
    check("L1 mid reset rsp_valid", 32'(lane[1].rsp_valid), 0);
    check("L1 mid reset rsp_rdata", lane[1].rsp_rdata, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (lane[1].rsp_valid != '0) n++;
    end
    check("L1 no rsp after reset", 32'(n), 0);
    check("L1 rsp_rdata after reset", lane[1].rsp_rdata, 0);
    issue(1, 1'b0, 12'h007, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lane[1].rsp_valid[1] && n < 20);
    check("L1 post-reset read in time", 32'(n < 20), 1);
    check("L1 post-reset rsp_rdata", lane[1].rsp_rdata, 32'hC0DE_0007);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
